regularization_multi: RTL

- Multi-channel successor to the single-channel debounce/regularization block.
- Each of N_CH asynchronous comparator/switch inputs is synchronised, then debounced (stable for a programmable cycle count).
- Each channel is then regularised: after any output transition, further transitions are locked out for a programmable dwell time.
- Adds per-channel enable, an edge strobe, a lockout status flag and a saturating count of debounced edges rejected during lockout. It sits between the sensing front-end and the hybrid-control switching logic.

---
 rtl/regularization_pkg.sv | 15 +
 rtl/regularization_ch.sv | 139 +++++++++++++
 rtl/regularization_multi.sv | 42 ++++
 3 files changed

// File: rtl/regularization_pkg.sv
// rtl/regularization_pkg.sv - shared types and default sizes for the multi-channel regularizer
package regularization_pkg;

   // Default widths and synchroniser depth used by the channel and the top level
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_REJ_W       = 8;
   localparam int DEF_SYNC_STAGES = 2;

   // Per-channel regularization state
   typedef enum logic {
      REG_IDLE = 1'b0,
      REG_LOCK = 1'b1
   } reg_state_e;

endpackage

// File: rtl/regularization_ch.sv
// rtl/regularization_ch.sv - one channel: synchroniser, debounce filter and lockout FSM
module regularization_ch
   import regularization_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int REJ_W       = DEF_REJ_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_signal,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] debounce_limit,
   input  logic [CNT_W-1:0] delay,
   output logic             o_signal,
   output logic             o_edge,
   output logic             o_locked,
   output logic [REJ_W-1:0] o_reject_cnt
);

   localparam logic [REJ_W-1:0] REJ_MAX = {REJ_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   logic                   deb_q;
   logic                   deb_d;
   logic [CNT_W-1:0]       deb_cnt_q;
   logic [CNT_W-1:0]       deb_cnt_d;
   logic                   deb_hit;
   logic                   deb_upd;

   reg_state_e             state_q;
   logic [CNT_W-1:0]       lock_cnt_q;
   logic                   sig_q;
   logic                   edge_q;
   logic                   locked_q;
   logic [REJ_W-1:0]       rej_q;

   // Shift the raw asynchronous input through the metastability chain
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_signal};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // A limit of 0 or 1 both mean "accept after a single differing cycle"
   assign deb_hit = (debounce_limit <= CNT_W'(1)) ||
                    (deb_cnt_q >= (debounce_limit - CNT_W'(1)));

   // Debounce next-state: count consecutive cycles that sync disagrees with deb_q
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      if (sync == deb_q) begin
         deb_cnt_d = '0;
      end else if (deb_hit) begin
         deb_d     = sync;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
   end

   assign deb_upd = (deb_d != deb_q);

   // Debounced level and its stability counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         deb_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Lockout FSM with registered output, edge strobe, lock flag and reject counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= REG_IDLE;
         lock_cnt_q <= '0;
         sig_q      <= 1'b0;
         edge_q     <= 1'b0;
         locked_q   <= 1'b0;
         rej_q      <= '0;
      end else if (!i_enable) begin
         // Disabled: output level and reject count freeze, any lockout is dropped
         state_q    <= REG_IDLE;
         lock_cnt_q <= '0;
         edge_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         edge_q <= 1'b0;
         case (state_q)
            REG_IDLE: begin
               if (deb_q != sig_q) begin
                  sig_q  <= deb_q;
                  edge_q <= 1'b1;
                  if (delay != '0) begin
                     lock_cnt_q <= CNT_W'(1);
                     locked_q   <= 1'b1;
                     state_q    <= REG_LOCK;
                  end
               end
            end
            REG_LOCK: begin
               // Debounced transitions arriving now are dropped; only the final level survives
               if (deb_upd && (rej_q != REJ_MAX)) begin
                  rej_q <= rej_q + REJ_W'(1);
               end
               // Live compare so that shrinking delay ends the lockout promptly
               if (lock_cnt_q >= delay) begin
                  lock_cnt_q <= '0;
                  locked_q   <= 1'b0;
                  state_q    <= REG_IDLE;
               end else begin
                  lock_cnt_q <= lock_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               lock_cnt_q <= '0;
               locked_q   <= 1'b0;
               state_q    <= REG_IDLE;
            end
         endcase
      end
   end

   assign o_signal     = sig_q;
   assign o_edge       = edge_q;
   assign o_locked     = locked_q;
   assign o_reject_cnt = rej_q;

endmodule

// File: rtl/regularization_multi.sv
// rtl/regularization_multi.sv - N_CH independent debounce/regularization channels with packed outputs
module regularization_multi
   import regularization_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int REJ_W       = DEF_REJ_W
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [N_CH-1:0]       i_signal,
   input  logic [N_CH-1:0]       i_enable,
   input  logic [CNT_W-1:0]      debounce_limit,
   input  logic [CNT_W-1:0]      delay,
   output logic [N_CH-1:0]       o_signal,
   output logic [N_CH-1:0]       o_edge,
   output logic [N_CH-1:0]       o_locked,
   output logic [N_CH*REJ_W-1:0] o_reject_cnt
);

   // One channel per input bit; shared limits fan out to every channel
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      regularization_ch #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .REJ_W       (REJ_W)
      ) u_ch (
         .i_clk          (i_clk),
         .i_reset        (i_reset),
         .i_signal       (i_signal[k]),
         .i_enable       (i_enable[k]),
         .debounce_limit (debounce_limit),
         .delay          (delay),
         .o_signal       (o_signal[k]),
         .o_edge         (o_edge[k]),
         .o_locked       (o_locked[k]),
         .o_reject_cnt   (o_reject_cnt[k*REJ_W +: REJ_W])
      );
   end

endmodule
